// File: rtl/tpu_pkg.sv
// Shared types for the result streaming path.
//   DATA_W      : default element width
//   tile_t      : 2x2 result tile, row-major, c00 in the most significant slot
//   ser_state_e : serializer state encoding
package tpu_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned TILE_ELEMS = 4;

  typedef struct packed {
    logic [DATA_W-1:0] c00;
    logic [DATA_W-1:0] c01;
    logic [DATA_W-1:0] c10;
    logic [DATA_W-1:0] c11;
  } tile_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/tile_fifo.sv
// Tile FIFO: one entry holds a whole packed tile.
//   clk, rst_n  : clock, async active-low reset (clears pointers only)
//   push_i      : write push_data_i at the tail (caller guarantees not full)
//   pop_i       : drop the head entry (caller guarantees not empty)
//   head_o      : current head entry
//   full_o      : all DEPTH entries occupied
//   empty_o     : no entries
//   count_o     : occupancy, 0..DEPTH
module tile_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PTR_W'(1);
      if (pop_i)  rptr_q <= rptr_q + PTR_W'(1);
    end
  end

  // Storage is not reset; emptiness is decided by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[ADDR_W-1:0]] <= push_data_i;
  end

  assign head_o  = mem_q[rptr_q[ADDR_W-1:0]];
  assign count_o = wptr_q - rptr_q;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) &&
                   (wptr_q[ADDR_W] != rptr_q[ADDR_W]);

endmodule

// File: rtl/result_streamer.sv
// Result streamer: buffers 2x2 result tiles and serializes them byte by byte.
//   clk, reset         : clock, async active-low reset
//   cap_valid, c00..c11: tile offer; captured when cap_ready is high
//   cap_ready          : FIFO has room (registered state only)
//   out_data/out_valid : serialized element stream, row-major
//   out_ready          : downstream accept
//   out_last           : final element (c11) of a tile
//   overflow           : sticky, a tile was offered while cap_ready was low
//   tiles_sent         : wrapping count of fully transmitted tiles
module result_streamer
  import tpu_pkg::ser_state_e;
  import tpu_pkg::ST_IDLE;
  import tpu_pkg::ST_SEND;
#(
  parameter int unsigned DATA_W = tpu_pkg::DATA_W,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_valid,
  input  logic [DATA_W-1:0] c00,
  input  logic [DATA_W-1:0] c01,
  input  logic [DATA_W-1:0] c10,
  input  logic [DATA_W-1:0] c11,
  output logic              cap_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              overflow,
  output logic [7:0]        tiles_sent
);

  localparam int unsigned PTR_W  = $clog2(DEPTH) + 1;
  localparam int unsigned TILE_W = 4 * DATA_W;

  ser_state_e        state_q;
  logic [1:0]        idx_q;
  logic              alive_q;
  logic              overflow_q;
  logic [7:0]        tiles_q;

  logic [TILE_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PTR_W-1:0]  fifo_count;
  logic              push;
  logic              pop;
  logic              xfer;

  // alive_q keeps cap_ready low until the first edge after reset release.
  assign cap_ready = alive_q & ~fifo_full;
  assign push      = cap_valid & cap_ready;
  assign out_valid = (state_q == ST_SEND);
  assign xfer      = out_valid & out_ready;
  assign pop       = xfer & (idx_q == 2'd3);
  assign out_last  = out_valid & (idx_q == 2'd3);
  assign overflow  = overflow_q;
  assign tiles_sent = tiles_q;

  tile_fifo #(
    .WIDTH (TILE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (push),
    .push_data_i ({c00, c01, c10, c11}),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Element select from the head tile; forced to zero when nothing is offered.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      case (idx_q)
        2'd0:    out_data = head[4*DATA_W-1 -: DATA_W];
        2'd1:    out_data = head[3*DATA_W-1 -: DATA_W];
        2'd2:    out_data = head[2*DATA_W-1 -: DATA_W];
        default: out_data = head[DATA_W-1 -: DATA_W];
      endcase
    end
  end

  // Serializer FSM, byte index, flags and tile counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      alive_q    <= 1'b0;
      overflow_q <= 1'b0;
      tiles_q    <= 8'd0;
    end else begin
      alive_q <= 1'b1;
      if (cap_valid && !cap_ready) overflow_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q <= ST_SEND;
            idx_q   <= 2'd0;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (idx_q == 2'd3) begin
              tiles_q <= tiles_q + 8'd1;
              idx_q   <= 2'd0;
              // Stay in SEND (no bubble) if anything is left after the pop,
              // including a tile pushed on this same edge.
              if (fifo_count == PTR_W'(1) && !push) state_q <= ST_IDLE;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_streamer.sv
// Bench for result_streamer: a tile-level reference model predicts acceptance,
// overflow and the byte stream; a monitor pops expected bytes on each transfer.
module tb_result_streamer;

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cap_valid = 1'b0;
  logic [W-1:0] c00 = '0, c01 = '0, c10 = '0, c11 = '0;
  logic         cap_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;
  logic         overflow;
  logic [7:0]   tiles_sent;

  result_streamer #(.DATA_W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .cap_valid  (cap_valid),
    .c00        (c00),
    .c01        (c01),
    .c10        (c10),
    .c11        (c11),
    .cap_ready  (cap_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .overflow   (overflow),
    .tiles_sent (tiles_sent)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] d;
    bit         last;
    int         cyc;
  } exp_t;

  exp_t       sbq[$];
  int         model_tiles = 0;
  bit         alive_m = 0;
  bit         ovf_m = 0;
  logic [7:0] sent_m = 8'd0;
  bit         prev_stall = 0;
  int         cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Model + monitor, sampled on the falling edge, updated for the coming rising edge.
  always @(negedge clk) begin
    bit   model_ready;
    exp_t e;
    cyc++;
    if (!reset) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_cap_ready", 32'(cap_ready), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_tiles_sent", 32'(tiles_sent), 32'd0);
      sbq.delete();
      model_tiles = 0;
      alive_m     = 0;
      ovf_m       = 0;
      sent_m      = 8'd0;
      prev_stall  = 0;
    end else begin
      model_ready = alive_m && (model_tiles < int'(DEPTH));
      check("cap_ready", 32'(cap_ready), 32'(model_ready));
      check("overflow", 32'(overflow), 32'(ovf_m));
      check("tiles_sent", 32'(tiles_sent), 32'(sent_m));
      if (prev_stall) check("hold_valid", 32'(out_valid), 32'd1);
      if (sbq.size() > 0 && sbq[0].cyc <= cyc - 2) check("no_bubble", 32'(out_valid), 32'd1);
      if (out_valid) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL stray_byte: got %0d expected no byte (cycle %0d)", out_data, cyc);
        end else begin
          check("out_data", 32'(out_data), 32'(sbq[0].d));
          check("out_last", 32'(out_last), 32'(sbq[0].last));
        end
      end else begin
        check("last_no_valid", 32'(out_last), 32'd0);
      end
      if (out_valid && out_ready && sbq.size() > 0) begin
        if (sbq[0].last) begin
          model_tiles--;
          sent_m = sent_m + 8'd1;
        end
        void'(sbq.pop_front());
      end
      if (cap_valid) begin
        if (model_ready) begin
          e.cyc = cyc;
          e.last = 0; e.d = c00; sbq.push_back(e);
          e.d = c01; sbq.push_back(e);
          e.d = c10; sbq.push_back(e);
          e.last = 1; e.d = c11; sbq.push_back(e);
          model_tiles++;
        end else begin
          ovf_m = 1;
        end
      end
      prev_stall = out_valid && !out_ready;
      alive_m    = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    cap_valid = 1'b1;
    c00 = a; c01 = b; c10 = c; c11 = d;
    step();
    cap_valid = 1'b0;
  endtask

  task automatic do_reset();
    cap_valid = 1'b0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    step();
  endtask

  task automatic drain(input int budget);
    out_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (sbq.size() == 0 && !out_valid) break;
      step();
    end
    check("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    do_reset();

    // Single tile, 1-cycle latency, four consecutive bytes.
    out_ready = 1'b1;
    offer(8'd1, 8'd2, 8'd3, 8'd4);
    check("lat_idle", 32'(out_valid), 32'd0);
    step();
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_byte", 32'(out_data), 32'd1);
    step();
    check("byte2", 32'(out_data), 32'd2);
    step();
    check("byte3_last", 32'(out_last), 32'd0);
    step();
    check("byte4", 32'(out_data), 32'd4);
    check("byte4_last", 32'(out_last), 32'd1);
    step();
    check("single_sent", 32'(tiles_sent), 32'd1);
    check("single_idle", 32'(out_valid), 32'd0);

    // Backpressure at index 1.
    offer(8'd1, 8'd2, 8'd3, 8'd4);
    step();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_data", 32'(out_data), 32'd2);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      step();
    end
    out_ready = 1'b1;
    repeat (4) step();
    check("bp_sent", 32'(tiles_sent), 32'd2);

    // Full FIFO and overflow.
    out_ready = 1'b0;
    cap_valid = 1'b1;
    c00 = 8'd10; c01 = 8'd11; c10 = 8'd12; c11 = 8'd13;
    step();
    c00 = 8'd20; c01 = 8'd21; c10 = 8'd22; c11 = 8'd23;
    step();
    check("full_cap_ready", 32'(cap_ready), 32'd0);
    c00 = 8'd30; c01 = 8'd31; c10 = 8'd32; c11 = 8'd33;
    step();
    cap_valid = 1'b0;
    check("ovf_set", 32'(overflow), 32'd1);
    drain(40);
    check("full_sent", 32'(tiles_sent), 32'd4);

    // Full with a simultaneous pop: offer refused, room the next cycle.
    do_reset();
    out_ready = 1'b0;
    offer(8'd61, 8'd62, 8'd63, 8'd64);
    offer(8'd71, 8'd72, 8'd73, 8'd74);
    out_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_last) begin
        found = 1;
        break;
      end
      step();
    end
    check("wait_last", 32'(found), 32'd1);
    offer(8'd81, 8'd82, 8'd83, 8'd84);
    check("pop_ovf", 32'(overflow), 32'd1);
    check("pop_cap_ready", 32'(cap_ready), 32'd1);
    drain(40);
    check("pop_sent", 32'(tiles_sent), 32'd2);

    // Counter wrap over 256 tiles.
    do_reset();
    out_ready = 1'b1;
    for (int t = 0; t < 256; t++) begin
      for (int k = 0; k < 20 && !cap_ready; k++) step();
      if (!cap_ready) begin
        check("wrap_ready_timeout", 32'(cap_ready), 32'd1);
        break;
      end
      offer(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      step();
      step();
      step();
    end
    drain(60);
    check("wrap_sent", 32'(tiles_sent), 32'd0);

    // Reset mid-tile at index 2 with another tile queued.
    do_reset();
    out_ready = 1'b0;
    offer(8'd41, 8'd42, 8'd43, 8'd44);
    offer(8'd51, 8'd52, 8'd53, 8'd54);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    check("pre_rst_idx2", 32'(out_data), 32'd43);
    reset = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_data", 32'(out_data), 32'd0);
    check("async_cap_ready", 32'(cap_ready), 32'd0);
    step();
    step();
    reset = 1'b1;
    step();
    step();
    out_ready = 1'b1;
    offer(8'd5, 8'd6, 8'd7, 8'd8);
    repeat (6) step();
    check("post_rst_sent", 32'(tiles_sent), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      cap_valid = ($urandom_range(0, 99) < 40);
      c00 = 8'($urandom); c01 = 8'($urandom);
      c10 = 8'($urandom); c11 = 8'($urandom);
      out_ready = ($urandom_range(0, 99) < 70);
      step();
    end
    cap_valid = 1'b0;
    drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/result_streamer.md
RESULT_STREAMER -- requirements
Module: result_streamer

Interface
REQ-001 Parameter DATA_W, default 8, element width in bits.
REQ-002 Parameter DEPTH, default 2, tile FIFO depth in tiles; power of two, at least 2.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset; assertion clears all state immediately; release is synchronous to clk.
REQ-005 Port cap_valid  input  1  a 2x2 result tile is present on c00..c11.
REQ-006 Port c00, c01, c10, c11  input  DATA_W each  result tile elements (row, column).
REQ-007 Port cap_ready  output  1  the block can accept a tile this cycle.
REQ-008 Port out_data  output  DATA_W  serialized result byte.
REQ-009 Port out_valid  output  1  out_data holds a valid byte.
REQ-010 Port out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 Port out_last  output  1  marks the final byte of a tile (c11).
REQ-012 Port overflow  output  1  sticky flag: a tile was offered while cap_ready was low.
REQ-013 Port tiles_sent  output  8  count of fully transmitted tiles.

Function
REQ-014 A tile is captured when cap_valid and cap_ready are both high at a rising edge; all four elements are written as one FIFO entry.
REQ-015 cap_ready is high exactly when the FIFO is not full; it is derived from registered state only and never combinationally from out_ready.
REQ-016 When the FIFO is full, a capture is refused even if the last byte of the head tile is popped in the same cycle.
REQ-017 When cap_valid is high and cap_ready is low, overflow sets on that edge and the tile is dropped; overflow clears only on reset.
REQ-018 Serializer FSM has two states: IDLE (FIFO empty, out_valid=0) and SEND (byte index 0..3).
REQ-019 IDLE->SEND on the edge after the FIFO becomes non-empty; out_valid first rises the cycle after capture into an empty FIFO (1-cycle latency), index=0.
REQ-020 Byte order is row-major: index 0=c00, 1=c01, 2=c10, 3=c11; out_last = (index==3) and out_valid.
REQ-021 A byte transfers when out_valid and out_ready are both high; the index then advances by one.
REQ-022 While out_valid is high and out_ready is low, out_data, out_last and out_valid hold stable.
REQ-023 On transfer of index 3 the head entry pops. If another entry remains, the FSM stays in SEND with index=0 and out_valid stays high, giving no bubble. Otherwise it goes to IDLE.
REQ-024 Simultaneous capture and pop with the FIFO not full: both take effect and occupancy is unchanged.
REQ-025 tiles_sent increments on each index-3 transfer and wraps from 255 to 0.
REQ-026 FIFO pointers wrap modulo DEPTH; occupancy is tracked with a pointer width of log2(DEPTH)+1 bits.

Reset
REQ-027 While reset is low: FSM=IDLE, index=0, FIFO empty, out_valid=0, out_last=0, out_data=0, cap_ready=0, overflow=0, tiles_sent=0.
REQ-028 cap_ready rises on the first clk edge after reset deasserts.
REQ-029 Reset asserted mid-tile discards all buffered tiles and the partially sent tile; no further bytes are emitted for them.

Structure
REQ-030 Shared package tpu_pkg holds DATA_W, the 2x2 tile struct type, and the serializer state enum.
REQ-031 Tile storage is one sub-module, tile_fifo, with synchronous push/pop, full/empty outputs and a head-entry output; result_streamer holds the FSM, counters and flags.

Verification
REQ-032 Single tile: capture {c00=1,c01=2,c10=3,c11=4} with out_ready=1 -> bytes 1,2,3,4 on four consecutive cycles starting one cycle after capture; out_last only on 4; tiles_sent=1.
REQ-033 Backpressure: same tile, out_ready low for 3 cycles at index 1 -> out_data holds 2 with out_valid high, then 3,4 follow; no byte is lost or duplicated.
REQ-034 Full/overflow: out_ready=0, offer tiles A={10,11,12,13}, B={20,21,22,23}, C={30,31,32,33} on consecutive cycles -> cap_ready low after B, overflow=1, C dropped; release -> stream 10..13, 20..23 back-to-back; tiles_sent=2.
REQ-035 Full with simultaneous pop: FIFO full, offer a tile on the cycle byte 3 of the head transfers -> tile refused, overflow=1; the next cycle cap_ready=1.
REQ-036 Wrap: stream 256 tiles -> tiles_sent reads 0; the last tile's bytes match the input.
REQ-037 Reset mid-operation: assert reset while index=2 with 1 tile queued -> outputs match REQ-027 immediately; after release, no stale bytes appear and a new tile {5,6,7,8} streams correctly.
